seq_pipe_rr_arb_stage: RTL
==========================

// Module: seq_pipe_rr_arb_stage
//
// PURPOSE
//  Shares one registered pipeline stage (single-stage W-bit delay register) among NREQ
//  val/rdy requesters under round-robin arbitration. Winning requester's data is
//  captured in the stage register and presented downstream one cycle later with its
//  source ID. Sits between producer ports and a shared downstream consumer.
//
// PARAMETERS
//  NREQ   4   number of requesters, >= 2
//  W      8   data width in bits
//  IDW    $clog2(NREQ)  source-ID width (derived, not overridable)
//
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  reset_n    in   1        synchronous active-low reset
//  req_val    in   NREQ     requester i has valid data
//  req_data   in   NREQ*W   requester i data at [i*W +: W]
//  req_rdy    out  NREQ     requester i transfer accepted this cycle
//  out_val    out  1        stage register holds valid data
//  out_data   out  W        stage register data
//  out_src    out  IDW      requester index that produced out_data
//  out_rdy    in   1        downstream accepts out_data this cycle
//
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): full=0, out_val=0, out_data=0, out_src=0, ptr=0.
//    Reset mid-transfer discards stage contents; req_rdy=0 while reset_n=0.
//  - Transfer rule: a handshake occurs when val && rdy in the same cycle.
//  - can_accept = !full || out_rdy (pipelined: drain and refill in one cycle).
//  - Arbitration (comb.): winner = first i with req_val[i]=1, searching ptr, ptr+1, ...,
//    NREQ-1, 0, ... ptr-1. At most one req_rdy bit high; req_rdy[winner]=can_accept.
//    req_rdy must not depend on req_data; may depend on req_val and out_rdy.
//  - On accept: out_data<=req_data[winner], out_src<=winner, full<=1,
//    ptr<=(winner+1) mod NREQ (wraps NREQ-1 -> 0).
//  - No accept, full && out_rdy: full<=0; out_data/out_src hold stale value.
//  - No request or !can_accept: ptr unchanged (no priority rotation without a grant).
//  - out_val = full. Latency: accepted data visible on out_data next cycle (1 cycle).
//  - Throughput: 1 item/cycle while out_rdy=1. Full && !out_rdy: all req_rdy=0,
//    stage holds out_data/out_src stable until out_rdy=1.
//  - Fairness: a continuously asserted requester is granted within NREQ accepts.
//
// CONFIGURATION
//  - Macro SEQ_PIPE_ARB_STALL_CNT_EN:
//    defined: adds output stall_cnt [7:0]; reset 0; increments each cycle
//      out_val && !out_rdy, saturates at 8'hFF; never clears except on reset.
//    undefined: port and counter absent; all other behaviour identical.
//
// TESTING
//  1. Reset: hold reset_n=0 2 cycles with req_val=4'hF -> req_rdy=0, out_val=0,
//     out_data=0, out_src=0; after release first grant goes to req 0.
//  2. Single requester: req_val=4'b0100, data2=8'hA5, out_rdy=1 -> req_rdy=4'b0100;
//     next cycle out_val=1, out_data=8'hA5, out_src=2.
//  3. Round robin: req_val=4'hF held, out_rdy=1, data i=8'h10+i -> out_src sequence
//     0,1,2,3,0 on consecutive cycles, out_data 10,11,12,13,10.
//  4. Backpressure: stage full with 8'h3C, out_rdy=0 for 3 cycles, req_val=4'hF ->
//     req_rdy=0, out_data=8'h3C stable; on out_rdy=1 same-cycle refill, ptr advances once.
//  5. Wrap/skip: ptr=3, req_val=4'b0010 -> winner 1, next ptr=2; then req_val=4'b1001
//     -> winner 3, next ptr=0.
//  6. STALL_CNT_EN build: full with out_rdy=0 for 300 cycles -> stall_cnt=8'hFF,
//     holds at 8'hFF; reset_n=0 -> 0.

Source files
------------

// File: rtl/seq_pipe_rr_arb_stage.sv
// -----------------------------------------------------------------------------
// seq_pipe_rr_arb_stage
//
// Purpose:
//   Lets NREQ val/rdy producers share one registered pipeline stage through
//   round-robin arbitration. The winning producer's data is captured in the
//   stage register. It appears downstream one cycle later, tagged with the
//   index of the producer that sent it. The stage can drain and refill in the
//   same cycle, so it sustains one item per cycle while out_rdy is held high.
//
// Parameters:
//   NREQ  number of requesters (>= 2)
//   W     data width in bits
//   IDW   source-ID width, derived as $clog2(NREQ)
//
// Ports:
//   clk        in   1        clock; all state changes on the rising edge
//   reset_n    in   1        synchronous active-low reset
//   req_val    in   NREQ     requester i offers data
//   req_data   in   NREQ*W   requester i data at [i*W +: W]
//   req_rdy    out  NREQ     requester i is accepted this cycle (one-hot or 0)
//   out_val    out  1        stage register holds valid data
//   out_data   out  W        stage register data
//   out_src    out  IDW      index of the requester that produced out_data
//   out_rdy    in   1        downstream takes out_data this cycle
//   stall_cnt  out  8        (SEQ_PIPE_ARB_STALL_CNT_EN only) saturating count
//                            of cycles with out_val && !out_rdy
//
// Configuration:
//   SEQ_PIPE_ARB_STALL_CNT_EN - when defined, adds the stall_cnt output and its
//   counter. When it is undefined, the port and counter are absent.
// -----------------------------------------------------------------------------
module seq_pipe_rr_arb_stage #(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_val,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_rdy,
    output logic              out_val,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_src,
    input  logic              out_rdy
`ifdef SEQ_PIPE_ARB_STALL_CNT_EN
    ,
    output logic [7:0]        stall_cnt
`endif
);

    logic            full_q, full_d;
    logic [W-1:0]    data_q, data_d;
    logic [IDW-1:0]  src_q, src_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic [IDW-1:0]  winner_s;
    logic            found_s;
    logic            hit_s;
    int              idx_s;
    logic            can_accept_s;
    logic            accept_s;
    logic [NREQ-1:0] req_rdy_s;

    // Round-robin search: the first active requester at or after ptr, wrapping around.
    always_comb begin
        winner_s = {IDW{1'b0}};
        found_s  = 1'b0;
        hit_s    = 1'b0;
        idx_s    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s    = (int'(ptr_q) + k) % NREQ;
            hit_s    = !found_s && req_val[idx_s];
            winner_s = hit_s ? IDW'(idx_s) : winner_s;
            found_s  = found_s | hit_s;
        end
    end

    // Handshake, grant and next-state logic for the stage register and priority pointer.
    always_comb begin
        // A full stage can still accept when downstream drains it in the same cycle.
        can_accept_s = !full_q || out_rdy;
        // Gating with reset_n keeps req_rdy low for as long as reset is held.
        accept_s     = reset_n && found_s && can_accept_s;
        req_rdy_s    = {NREQ{1'b0}};
        full_d       = full_q;
        data_d       = data_q;
        src_d        = src_q;
        ptr_d        = ptr_q;
        if (accept_s) begin
            req_rdy_s[winner_s] = 1'b1;
            full_d              = 1'b1;
            data_d              = req_data[int'(winner_s)*W +: W];
            src_d               = winner_s;
            // The pointer rotates only on a grant, to the slot just past the winner.
            if (winner_s == IDW'(NREQ - 1)) begin
                ptr_d = {IDW{1'b0}};
            end else begin
                ptr_d = winner_s + IDW'(1);
            end
        end else if (full_q && out_rdy) begin
            // The stage drains without a refill. The stale data and source ID are kept.
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Stage register and priority pointer, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= {W{1'b0}};
            src_q  <= {IDW{1'b0}};
            ptr_q  <= {IDW{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            src_q  <= src_d;
            ptr_q  <= ptr_d;
        end
    end

    assign req_rdy  = req_rdy_s;
    assign out_val  = full_q;
    assign out_data = data_q;
    assign out_src  = src_q;

`ifdef SEQ_PIPE_ARB_STALL_CNT_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which valid output is held back by downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (full_q && !out_rdy && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= 8'h00;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
